// File: rtl/sprite_renderer.sv
// sprite_renderer: two-stage VGA pixel colouring of frame-latched sprite rectangles over a centre net.
package sprite_pkg;
  localparam int N_SPRITES    = 3;
  localparam int X_POS_W      = 10;
  localparam int Y_POS_W      = 10;
  localparam int SCREEN_H_RES = 640;
  localparam int SCREEN_V_RES = 480;
  typedef struct packed {
    logic [X_POS_W-1:0] x_pos;
    logic [Y_POS_W-1:0] y_pos;
    logic [X_POS_W-1:0] right;
    logic [Y_POS_W-1:0] bottom;
  } sprite_t;
endpackage

module sprite_renderer #(
  parameter int COLOR_W = 4,
  parameter int N_SPRITES = sprite_pkg::N_SPRITES,
  parameter logic [3*COLOR_W-1:0] BG_RGB = 12'h000,
  parameter logic [3*COLOR_W-1:0] NET_RGB = 12'h888,
  parameter logic [3*COLOR_W-1:0] SPRITE_RGB [N_SPRITES] = '{12'h0F0, 12'hF00, 12'hFFF}
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         hsync_i,
  input  logic                         vsync_i,
  input  logic                         display_on_i,
  input  logic [sprite_pkg::X_POS_W-1:0] x_pos_i,
  input  logic [sprite_pkg::Y_POS_W-1:0] y_pos_i,
  input  sprite_pkg::sprite_t          sprites_i [N_SPRITES],
  output logic                         new_frame_o,
  output logic                         hsync_o,
  output logic                         vsync_o,
  output logic [COLOR_W-1:0]           red_o,
  output logic [COLOR_W-1:0]           green_o,
  output logic [COLOR_W-1:0]           blue_o
);
  localparam int XW = sprite_pkg::X_POS_W;
  localparam int YW = sprite_pkg::Y_POS_W;
  localparam logic [XW-1:0] NET_X0 = XW'(sprite_pkg::SCREEN_H_RES / 2 - 1);
  localparam logic [XW-1:0] NET_X1 = XW'(sprite_pkg::SCREEN_H_RES / 2);
  localparam logic [YW-1:0] V_RES  = YW'(sprite_pkg::SCREEN_V_RES);
  sprite_pkg::sprite_t shadow_q [N_SPRITES];
  logic armed_q, new_frame_q, frame_end;
  logic [N_SPRITES-1:0] hit_d, hit_q;
  logic net_d, net_q, de_q, hs_q, vs_q, hs2_q, vs2_q;
  logic [3*COLOR_W-1:0] rgb_d, rgb_q;
  // armed_q resets low so a y already at V_RES on release cannot look like an edge
  assign frame_end = armed_q && (y_pos_i == V_RES);
  always_comb begin
    hit_d = '0;
    for (int i = 0; i < N_SPRITES; i++)
      hit_d[i] = (x_pos_i >= shadow_q[i].x_pos) && (x_pos_i < shadow_q[i].right) &&
                 (y_pos_i >= shadow_q[i].y_pos) && (y_pos_i < shadow_q[i].bottom);
    net_d = ((x_pos_i == NET_X0) || (x_pos_i == NET_X1)) && !y_pos_i[4];
    rgb_d = !de_q    ? '0 :
            hit_q[2] ? SPRITE_RGB[2] :
            hit_q[0] ? SPRITE_RGB[0] :
            hit_q[1] ? SPRITE_RGB[1] :
            net_q    ? NET_RGB : BG_RGB;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      armed_q     <= 1'b0;
      new_frame_q <= 1'b0;
      for (int i = 0; i < N_SPRITES; i++) shadow_q[i] <= '0;
      hit_q       <= '0;
      net_q       <= 1'b0;
      de_q        <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      hs2_q       <= 1'b0;
      vs2_q       <= 1'b0;
      rgb_q       <= '0;
    end else begin
      armed_q     <= (y_pos_i != V_RES);
      new_frame_q <= frame_end;
      if (frame_end) shadow_q <= sprites_i;
      hit_q       <= hit_d;
      net_q       <= net_d;
      de_q        <= display_on_i;
      hs_q        <= hsync_i;
      vs_q        <= vsync_i;
      hs2_q       <= hs_q;
      vs2_q       <= vs_q;
      rgb_q       <= rgb_d;
    end
  end
  assign new_frame_o = new_frame_q;
  assign hsync_o = hs2_q;
  assign vsync_o = vs2_q;
  assign {red_o, green_o, blue_o} = rgb_q;
endmodule

// File: tb/tb_sprite_renderer.sv
// tb_sprite_renderer: directed pixels with hand-computed colours, checked by a latency-aware scoreboard monitor.
module tb_sprite_renderer;
  typedef struct {
    bit chk;
    int x, y;
    logic [11:0] rgb;
    logic hs, vs;
  } item_t;
  logic clk = 0, rst = 0, hs = 0, vs = 0, de = 0;
  logic [9:0] xp = 0, yp = 0;
  sprite_pkg::sprite_t spr [3];
  logic nf, hso, vso;
  logic [3:0] r, g, b;
  item_t q_pix [$];
  bit q_nf [$];
  bit issued = 0;
  logic [2:0] cyc = 0;
  int total = 0, bad = 0;

  sprite_renderer dut (
    .clk_i(clk), .rst_i(rst), .hsync_i(hs), .vsync_i(vs), .display_on_i(de),
    .x_pos_i(xp), .y_pos_i(yp), .sprites_i(spr),
    .new_frame_o(nf), .hsync_o(hso), .vsync_o(vso),
    .red_o(r), .green_o(g), .blue_o(b)
  );

  always #5 clk = ~clk;

  function automatic sprite_pkg::sprite_t mk(input int x, y, rt, bt);
    mk = '{x_pos: 10'(x), y_pos: 10'(y), right: 10'(rt), bottom: 10'(bt)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic px(input int x, input int y, input bit d, input bit c, input logic [11:0] rgb, input bit enf);
    item_t it;
    xp = 10'(x); yp = 10'(y); de = d;
    hs = cyc[0] ^ cyc[2]; vs = cyc[1];
    cyc++;
    issued = 1;
    it.chk = c; it.x = x; it.y = y; it.rgb = rgb; it.hs = hs; it.vs = vs;
    q_pix.push_back(it);
    q_nf.push_back(enf);
    @(negedge clk);
  endtask

  initial begin : monitor
    bit p1, p2;
    item_t it;
    bit enf;
    p1 = 0; p2 = 0;
    forever begin
      @(posedge clk);
      p2 = p1;
      p1 = issued;
      if (rst) begin p1 = 0; p2 = 0; end
      #1;
      if (p1) begin
        if (q_nf.size() == 0) chk("nf_queue_empty", 1, 0);
        else begin
          enf = q_nf.pop_front();
          chk($sformatf("new_frame y=%0d", yp), {31'd0, nf}, {31'd0, enf});
        end
      end
      if (p2) begin
        if (q_pix.size() == 0) chk("pix_queue_empty", 1, 0);
        else begin
          it = q_pix.pop_front();
          if (it.chk) chk($sformatf("rgb x=%0d y=%0d", it.x, it.y), {20'd0, r, g, b}, {20'd0, it.rgb});
          chk($sformatf("sync x=%0d y=%0d", it.x, it.y), {30'd0, hso, vso}, {30'd0, it.hs, it.vs});
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    for (int i = 0; i < 3; i++) spr[i] = '0;
    #1 rst = 1;
    #2;
    chk("reset_rgb", {20'd0, r, g, b}, 0);
    chk("reset_sync_nf", {29'd0, hso, vso, nf}, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    spr[0] = mk(10, 190, 40, 220);
    spr[1] = mk(600, 300, 610, 340);
    spr[2] = mk(100, 50, 108, 58);
    px(0, 0, 1, 1, 12'h000, 0);
    px(0, 479, 0, 1, 12'h000, 0);
    px(0, 480, 0, 1, 12'h000, 1);
    for (int i = 0; i < 10; i++) px(0, 480, 0, 1, 12'h000, 0);
    for (int x = 99; x <= 108; x++) px(x, 50, 1, 1, (x >= 100 && x <= 107) ? 12'hFFF : 12'h000, 0);
    px(319, 0, 1, 1, 12'h888, 0);
    px(320, 15, 1, 1, 12'h888, 0);
    px(320, 16, 1, 1, 12'h000, 0);
    px(321, 0, 1, 1, 12'h000, 0);
    px(318, 0, 1, 1, 12'h000, 0);
    px(605, 320, 1, 1, 12'hF00, 0);
    px(609, 339, 1, 1, 12'hF00, 0);
    px(600, 300, 1, 1, 12'hF00, 0);
    px(610, 320, 1, 1, 12'h000, 0);
    px(605, 340, 1, 1, 12'h000, 0);
    px(10, 190, 1, 1, 12'h0F0, 0);
    px(39, 219, 1, 1, 12'h0F0, 0);
    px(40, 219, 1, 1, 12'h000, 0);
    px(9, 190, 1, 1, 12'h000, 0);
    px(10, 189, 1, 1, 12'h000, 0);
    px(20, 200, 0, 1, 12'h000, 0);
    px(20, 200, 1, 1, 12'h0F0, 0);
    spr[1] = mk(25, 195, 35, 205);
    spr[2] = mk(16, 195, 24, 205);
    px(0, 100, 1, 1, 12'h000, 0);
    px(100, 50, 1, 1, 12'hFFF, 0);
    px(20, 200, 1, 1, 12'h0F0, 0);
    px(30, 200, 1, 1, 12'h0F0, 0);
    px(605, 320, 1, 1, 12'hF00, 0);
    px(0, 479, 0, 1, 12'h000, 0);
    px(0, 480, 0, 1, 12'h000, 1);
    px(20, 200, 1, 1, 12'hFFF, 0);
    px(16, 195, 1, 1, 12'hFFF, 0);
    px(23, 204, 1, 1, 12'hFFF, 0);
    px(24, 200, 1, 1, 12'h0F0, 0);
    px(30, 200, 1, 1, 12'h0F0, 0);
    px(100, 50, 1, 1, 12'h000, 0);
    px(605, 320, 1, 1, 12'h000, 0);
    px(0, 479, 0, 1, 12'h000, 0);
    spr[1] = mk(315, 0, 325, 10);
    spr[2] = mk(50, 50, 50, 60);
    px(0, 480, 0, 1, 12'h000, 1);
    px(0, 480, 0, 1, 12'h000, 0);
    px(20, 200, 1, 1, 12'h0F0, 0);
    px(50, 55, 1, 1, 12'h000, 0);
    px(30, 200, 1, 1, 12'h0F0, 0);
    px(319, 5, 1, 1, 12'hF00, 0);
    px(320, 12, 1, 1, 12'h888, 0);
    issued = 0;
    repeat (4) @(negedge clk);
    chk("queues_drained", q_pix.size() + q_nf.size(), 0);
    xp = 20; yp = 200; de = 1; hs = 1; vs = 1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("async_rst_rgb", {20'd0, r, g, b}, 0);
    chk("async_rst_sync_nf", {29'd0, hso, vso, nf}, 0);
    @(negedge clk);
    yp = 480;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 chk($sformatf("no_nf_after_release %0d", i), {31'd0, nf}, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sprite_renderer.md
SPRITE_RENDERER -- requirements
Module: sprite_renderer

Interface
REQ-001 Parameter COLOR_W, default 4, bit width of each colour channel.
REQ-002 Parameter N_SPRITES, default sprite_pkg::N_SPRITES (3), number of sprite inputs; index 0 player, 1 enemy, 2 ball.
REQ-003 Parameter BG_RGB, default 12'h000, background colour {R,G,B}.
REQ-004 Parameter NET_RGB, default 12'h888, centre-net colour.
REQ-005 Parameter SPRITE_RGB, default {12'h0F0, 12'hF00, 12'hFFF}, per-sprite colour, indexed by sprite number.
REQ-006 clk_i  input  1  system clock; the block uses one clock.
REQ-007 rst_i  input  1  reset, asynchronous, active-high.
REQ-008 hsync_i  input  1  horizontal sync from the VGA timing generator.
REQ-009 vsync_i  input  1  vertical sync from the VGA timing generator.
REQ-010 display_on_i  input  1  high while the current pixel is inside the visible area.
REQ-011 x_pos_i  input  X_POS_W  current pixel column.
REQ-012 y_pos_i  input  Y_POS_W  current pixel row.
REQ-013 sprites_i  sprite_if array [N_SPRITES]  read-only; sprite fields x_pos, y_pos, right, bottom.
REQ-014 new_frame_o  output  1  one-cycle strobe marking the end of the visible frame, consumed by game logic.
REQ-015 hsync_o, vsync_o  output  1 each  syncs delayed to align with the colour outputs.
REQ-016 red_o, green_o, blue_o  output  COLOR_W each  pixel colour.

Function
REQ-017 The renderer SHALL detect the frame end as the first cycle with y_pos_i == SCREEN_V_RES after a cycle with y_pos_i != SCREEN_V_RES.
REQ-018 new_frame_o SHALL be registered and high for exactly one cycle, in the cycle after the frame-end detection; it SHALL stay low in all other cycles.
REQ-019 Shadow copies of all N_SPRITES rectangles SHALL load from sprites_i on the same clock edge that raises new_frame_o; at all other times the shadow copies SHALL hold.
REQ-020 Rendering SHALL use the shadow copies only, so sprite changes mid-frame are never visible (no tearing).
REQ-021 Pipeline stage 1 SHALL register x_pos_i, y_pos_i, display_on_i, hsync_i, vsync_i and one hit bit per sprite.
REQ-022 The hit test SHALL be: hit = (x >= x_pos) && (x < right) && (y >= y_pos) && (y < bottom), using unsigned compares at full X_POS_W/Y_POS_W width.
REQ-023 A net hit SHALL be: x in {SCREEN_H_RES/2-1, SCREEN_H_RES/2} && y[4] == 0.
REQ-024 Stage 2 SHALL register the colour; priority is ball (2) > player (0) > enemy (1) > net > BG_RGB.
REQ-025 Colour outputs SHALL be 0 whenever the stage-1 display_on bit is low, regardless of hits.
REQ-026 Latency from x/y/sync inputs to colour and sync outputs SHALL be exactly 2 cycles; hsync_o and vsync_o are the inputs delayed by 2 cycles.
REQ-027 A degenerate sprite (right <= x_pos or bottom <= y_pos) SHALL never hit.
REQ-028 A sprite with right or bottom wrapped past its field width SHALL be treated as per REQ-022 with no special handling.
REQ-029 If frame-end detection and a sprite update coincide, the value present on sprites_i in the load cycle SHALL be captured.

Reset
REQ-030 While rst_i is high, all outputs SHALL be 0: new_frame_o, hsync_o, vsync_o, red_o, green_o and blue_o.
REQ-031 While rst_i is high, all pipeline registers and shadow sprites SHALL be 0, and the frame-end edge detector SHALL be cleared.
REQ-032 After reset release, the first new_frame_o SHALL occur only on a real y_pos_i transition into SCREEN_V_RES; a y_pos_i already equal to SCREEN_V_RES at release SHALL NOT produce a pulse.
REQ-033 Reset asserted mid-frame SHALL take effect immediately, without waiting for a clock edge.

Verification
REQ-034 Scenario 1: y_pos_i steps 479->480 at cycle N, then holds at 480 for 10 cycles -> new_frame_o = 1 at cycle N+1 only.
REQ-035 Scenario 2: ball shadow {x 100, y 50, right 108, bottom 58}, scan x = 99..108 at y = 50 -> white (FFF) for x = 100..107, two cycles later; x = 99 and x = 108 show BG.
REQ-036 Scenario 3: ball overlaps player at (20, 200) -> output FFF (ball wins); remove the ball -> 0F0.
REQ-037 Scenario 4: change sprites_i mid-frame at y = 100 -> no output change until after the next new_frame_o; the new position appears from the following frame.
REQ-038 Scenario 5: display_on_i = 0 with a pixel inside the player rectangle -> RGB = 0; hsync_o and vsync_o equal the inputs delayed by 2 cycles.
REQ-039 Scenario 6: assert rst_i asynchronously mid-line -> all outputs 0 before the next clock edge; after release with y_pos_i = 480, no new_frame_o pulse.
